// File: rtl/pwm_link_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_link_pkg
//  Purpose  : Shared FSM state codes, channel indices and rate defaults for
//             the PWM position link controller.
//  Revision : 1.0 - initial release
// ============================================================================
package pwm_link_pkg;

    typedef logic [2:0] state_t;

    // Binary-encoded controller states
    localparam state_t C_ST_IDLE  = 3'd0;
    localparam state_t C_ST_ARB   = 3'd1;
    localparam state_t C_ST_LOAD  = 3'd2;
    localparam state_t C_ST_SEND  = 3'd3;
    localparam state_t C_ST_CHECK = 3'd4;

    // Requester channel indices
    localparam logic C_CH_ENC  = 1'b0;
    localparam logic C_CH_DIAG = 1'b1;

    // Rate-select code applied out of reset
    localparam logic [2:0] C_RATE_DEFAULT = 3'b000;

endpackage
`default_nettype wire

// File: rtl/pwm_link_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-requester round-robin arbiter with a registered
//             last-grant pointer. Grant is combinational; the pointer only
//             moves when the caller commits a grant via advance_i.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
    import pwm_link_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);

    logic last_q;
    logic last_d;

    // Choose the winner; on contention the channel not served last wins
    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = (last_q == C_CH_DIAG) ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

    // Remember the channel that actually received a committed grant
    always_comb begin
        last_d = last_q;
        if (advance_i && (grant_o != 2'b00)) begin
            last_d = grant_o[1];
        end
    end

    // Pointer starts as "diag served last" so the encoder channel wins first
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_q <= C_CH_DIAG;
        end else begin
            last_q <= last_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_link_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_link_ctrl
//  Purpose  : Arbitrates two position requesters onto a PWM link, holds the
//             granted position for one frame of FRAME_TICKS pwm ticks, then
//             checks the loopback reply (match / mismatch / timeout).
//             Rate-select changes are deferred until the link is idle.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_link_ctrl
    import pwm_link_pkg::*;
#(
    parameter int FRAME_TICKS = 1040,
    parameter int RX_TIMEOUT  = 4096
)(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       pwm_tick_i,
    input  logic [1:0] req_i,
    input  logic [9:0] pos0_i,
    input  logic [9:0] pos1_i,
    input  logic       rate_wr_i,
    input  logic [2:0] rate_new_i,
    input  logic       rx_valid_i,
    input  logic [9:0] rx_pos_i,
    output logic [1:0] gnt_o,
    output logic [9:0] pos_out_o,
    output logic [2:0] rate_sel_o,
    output logic       busy_o,
    output logic       match_o,
    output logic       mismatch_o,
    output logic       timeout_o
);

    localparam int TICK_W = $clog2(FRAME_TICKS);
    localparam int TMO_W  = $clog2(RX_TIMEOUT);
    localparam logic [TICK_W-1:0] C_TICK_LAST = TICK_W'(FRAME_TICKS - 1);
    localparam logic [TMO_W-1:0]  C_TMO_LAST  = TMO_W'(RX_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              sel_q, sel_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [9:0]        pos_q, pos_d;
    logic [2:0]        rate_q, rate_d;
    logic              pend_q, pend_d;
    logic [2:0]        pend_code_q, pend_code_d;
    logic              match_q, match_d;
    logic              mismatch_q, mismatch_d;
    logic              timeout_q, timeout_d;

    logic [1:0]        arb_grant;
    logic              arb_advance;
    logic              frame_done;
    logic              wait_expired;

    assign frame_done   = pwm_tick_i && (tick_cnt_q == C_TICK_LAST);
    assign wait_expired = (tmo_cnt_q == C_TMO_LAST);

    rr_arb2 u_arb (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .req_i     (req_i),
        .advance_i (arb_advance),
        .grant_o   (arb_grant)
    );

    // FSM state register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= C_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: a pending rate change holds the link in IDLE for a cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_IDLE:  if (!pend_q && (req_i != 2'b00)) state_d = C_ST_ARB;
            C_ST_ARB:   state_d = (req_i != 2'b00) ? C_ST_LOAD : C_ST_IDLE;
            C_ST_LOAD:  state_d = C_ST_SEND;
            C_ST_SEND:  if (frame_done) state_d = C_ST_CHECK;
            C_ST_CHECK: if (rx_valid_i || wait_expired) state_d = C_ST_IDLE;
            default:    state_d = C_ST_IDLE;
        endcase
    end

    // FSM outputs and datapath next values; rx_valid beats timeout expiry
    always_comb begin
        busy_o      = (state_q != C_ST_IDLE);
        arb_advance = 1'b0;
        gnt_d       = 2'b00;
        match_d     = 1'b0;
        mismatch_d  = 1'b0;
        timeout_d   = 1'b0;
        sel_d       = sel_q;
        pos_d       = pos_q;
        tick_cnt_d  = tick_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        rate_d      = rate_q;
        pend_d      = pend_q;
        pend_code_d = pend_code_q;
        case (state_q)
            C_ST_IDLE: begin
                if (pend_q) begin
                    rate_d = pend_code_q;
                    pend_d = 1'b0;
                end
            end
            C_ST_ARB: begin
                arb_advance = 1'b1;
                gnt_d       = arb_grant;
                if (arb_grant != 2'b00) begin
                    sel_d = arb_grant[1];
                end
            end
            C_ST_LOAD: begin
                pos_d      = (sel_q == C_CH_DIAG) ? pos1_i : pos0_i;
                tick_cnt_d = '0;
            end
            C_ST_SEND: begin
                if (frame_done) begin
                    tmo_cnt_d = '0;
                end else if (pwm_tick_i) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            C_ST_CHECK: begin
                if (rx_valid_i) begin
                    match_d    = (rx_pos_i == pos_q);
                    mismatch_d = (rx_pos_i != pos_q);
                end else if (wait_expired) begin
                    timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
        // A new write always lands in the pending slot, last one wins
        if (rate_wr_i) begin
            pend_d      = 1'b1;
            pend_code_d = rate_new_i;
        end
    end

    // Datapath and registered output pulses
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tick_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            sel_q       <= C_CH_ENC;
            gnt_q       <= 2'b00;
            pos_q       <= 10'd0;
            rate_q      <= C_RATE_DEFAULT;
            pend_q      <= 1'b0;
            pend_code_q <= C_RATE_DEFAULT;
            match_q     <= 1'b0;
            mismatch_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            pos_q       <= pos_d;
            rate_q      <= rate_d;
            pend_q      <= pend_d;
            pend_code_q <= pend_code_d;
            match_q     <= match_d;
            mismatch_q  <= mismatch_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt_o      = gnt_q;
    assign pos_out_o  = pos_q;
    assign rate_sel_o = rate_q;
    assign match_o    = match_q;
    assign mismatch_o = mismatch_q;
    assign timeout_o  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_link_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_link_ctrl
//  Purpose  : Self-checking bench for pwm_link_ctrl: a procedural frame-level
//             model predicts every output each cycle, plus directed scenarios
//             with literal expectations and a randomized soak.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_link_ctrl;

    localparam int FT = 1040;
    localparam int RT = 4096;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pwm_tick = 1'b0;
    logic [1:0] req = 2'b00;
    logic [9:0] pos0 = 10'd0;
    logic [9:0] pos1 = 10'd0;
    logic       rate_wr = 1'b0;
    logic [2:0] rate_new = 3'd0;
    logic       rx_valid = 1'b0;
    logic [9:0] rx_pos = 10'd0;

    logic [1:0] gnt;
    logic [9:0] pos_out;
    logic [2:0] rate_sel;
    logic       busy, match, mismatch, timeout;

    int n_tests = 0;
    int n_fail  = 0;
    bit tick_dense = 1'b1;
    bit cmp_en = 1'b0;

    pwm_link_ctrl #(.FRAME_TICKS(FT), .RX_TIMEOUT(RT)) dut (
        .clk_i(clk), .reset_i(reset), .pwm_tick_i(pwm_tick), .req_i(req),
        .pos0_i(pos0), .pos1_i(pos1), .rate_wr_i(rate_wr), .rate_new_i(rate_new),
        .rx_valid_i(rx_valid), .rx_pos_i(rx_pos), .gnt_o(gnt), .pos_out_o(pos_out),
        .rate_sel_o(rate_sel), .busy_o(busy), .match_o(match),
        .mismatch_o(mismatch), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: a frame is a sequence of waits, not a state machine
    // ------------------------------------------------------------------
    logic [1:0] m_gnt;
    logic [9:0] m_pos;
    logic [2:0] m_rate, m_pcode;
    bit m_busy, m_match, m_mis, m_tmo, m_pend, m_last, m_rst;
    bit m_in_send, m_in_check;
    logic [1:0] s_req;
    logic [9:0] s_pos0, s_pos1, s_rxpos;
    logic [2:0] s_rate_new;
    bit s_tick, s_rxv, s_rate_wr;

    task automatic m_reset_vals();
        m_gnt = 2'b00; m_pos = 10'd0; m_rate = 3'd0; m_busy = 0;
        m_match = 0; m_mis = 0; m_tmo = 0; m_pend = 0; m_pcode = 3'd0;
        m_last = 1; m_in_send = 0; m_in_check = 0; s_rate_wr = 0;
    endtask

    // Advance one clock (or an async reset); capture inputs seen at the edge
    task automatic mstep();
        if (s_rate_wr) begin m_pend = 1; m_pcode = s_rate_new; end
        s_rate_wr = 0;
        @(posedge clk or posedge reset);
        m_gnt = 2'b00; m_match = 0; m_mis = 0; m_tmo = 0;
        m_rst = reset;
        if (reset) begin m_reset_vals(); return; end
        s_req = req; s_tick = pwm_tick; s_pos0 = pos0; s_pos1 = pos1;
        s_rxv = rx_valid; s_rxpos = rx_pos; s_rate_wr = rate_wr; s_rate_new = rate_new;
    endtask

    task automatic frame_flow();
        bit go;
        bit ch;
        int ticks;
        go = 0;
        while (!go) begin
            mstep(); if (m_rst) return;
            if (m_pend) begin m_rate = m_pcode; m_pend = 0; end
            else if (s_req != 2'b00) go = 1;
        end
        m_busy = 1;
        mstep(); if (m_rst) return;
        if (s_req == 2'b00) begin m_busy = 0; return; end
        if (s_req == 2'b11) ch = ~m_last;
        else                ch = s_req[1];
        m_last = ch;
        m_gnt = ch ? 2'b10 : 2'b01;
        mstep(); if (m_rst) return;
        m_pos = ch ? s_pos1 : s_pos0;
        m_in_send = 1;
        ticks = 0;
        while (ticks < FT) begin
            mstep(); if (m_rst) return;
            if (s_tick) ticks++;
        end
        m_in_send = 0;
        m_in_check = 1;
        for (int w = 1; ; w++) begin
            mstep(); if (m_rst) return;
            if (s_rxv) begin
                if (s_rxpos == m_pos) m_match = 1; else m_mis = 1;
                break;
            end
            if (w == RT) begin m_tmo = 1; break; end
        end
        m_in_check = 0;
        m_busy = 0;
    endtask

    initial begin
        m_reset_vals();
        m_rst = 0;
        s_tick = 0; s_rxv = 0; s_req = 0; s_pos0 = 0; s_pos1 = 0; s_rxpos = 0; s_rate_new = 0;
        forever frame_flow();
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            n_tests++;
            if ({gnt, pos_out, rate_sel, busy, match, mismatch, timeout} !==
                {m_gnt, m_pos, m_rate, m_busy, m_match, m_mis, m_tmo}) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t dut gnt=%b pos=%0d rate=%b busy=%b m/mm/t=%b%b%b required gnt=%b pos=%0d rate=%b busy=%b m/mm/t=%b%b%b",
                         $time, gnt, pos_out, rate_sel, busy, match, mismatch, timeout,
                         m_gnt, m_pos, m_rate, m_busy, m_match, m_mis, m_tmo);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        rate_wr = 1'b0;
        rx_valid = 1'b0;
        pwm_tick = tick_dense ? 1'b1 : ($urandom_range(3) != 0);
    endtask

    task automatic wait_send(input string nm);
        int n = 0;
        while (!m_in_send && n < 100) begin cyc(); n++; end
        if (!m_in_send) chk({nm, "_send_wait"}, 0, 1);
    endtask

    task automatic wait_check(input string nm);
        int n = 0;
        while (!m_in_check && n < 3000) begin cyc(); n++; end
        if (!m_in_check) chk({nm, "_check_wait"}, 0, 1);
    endtask

    task automatic wait_gnt(input string nm, input int exp);
        int n = 0;
        do begin cyc(); n++; end while (gnt == 2'b00 && n < 20);
        chk(nm, int'(gnt), exp);
    endtask

    initial begin
        #20 cmp_en = 1'b1;
    end

    initial begin
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        // Reset state
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_pos", int'(pos_out), 0);
        chk("rst_rate", int'(rate_sel), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pulses", int'({match, mismatch, timeout}), 0);

        // Single encoder request, matching reply
        pos0 = 10'd1022; req = 2'b01;
        cyc();
        cyc();
        chk("t1_gnt_2cyc", int'(gnt), 1);
        chk("t1_model_gnt", int'(m_gnt), 1);
        req = 2'b00;
        cyc();
        chk("t1_pos", int'(pos_out), 1022);
        wait_check("t1");
        rx_valid = 1'b1; rx_pos = 10'd1022;
        cyc();
        chk("t1_result", int'({match, mismatch, timeout}), 3'b100);

        // Request dropped before arbitration: no grant, back to idle
        req = 2'b01;
        cyc();
        chk("drop_busy_arb", int'(busy), 1);
        req = 2'b00;
        cyc();
        chk("drop_busy", int'(busy), 0);
        chk("drop_gnt", int'(gnt), 0);

        // Both requesting for two frames from a fresh pointer
        reset = 1'b1; cyc(); cyc(); reset = 1'b0; cyc();
        pos0 = 10'd111; pos1 = 10'd222; req = 2'b11;
        wait_gnt("t2_gnt_a", 1);
        cyc();
        chk("t2_pos_a", int'(pos_out), 111);
        wait_check("t2a");
        rx_valid = 1'b1; rx_pos = 10'd111;
        cyc();
        wait_gnt("t2_gnt_b", 2);
        cyc();
        chk("t2_pos_b", int'(pos_out), 222);
        req = 2'b00;
        wait_check("t2b");
        rx_valid = 1'b1; rx_pos = 10'd222;
        cyc();

        // Rate writes mid-frame are deferred; the last write wins
        for (int k = 0; k < 2; k++) begin
            pos0 = 10'd5; req = 2'b01;
            wait_send("t3");
            req = 2'b00;
            rate_wr = 1'b1; rate_new = (k == 0) ? 3'b001 : 3'b010;
            repeat (6) cyc();
            chk("t3_rate_hold_a", int'(rate_sel), (k == 0) ? 0 : 1);
            if (k == 1) begin
                rate_wr = 1'b1; rate_new = 3'b111;
                cyc();
            end
            wait_check("t3");
            chk("t3_rate_hold_b", int'(rate_sel), (k == 0) ? 0 : 1);
            rx_valid = 1'b1; rx_pos = 10'd5;
            cyc();
            cyc();
            chk("t3_rate_applied", int'(rate_sel), (k == 0) ? 1 : 7);
        end

        // Mismatch, then a frame with no reply that must time out
        pos0 = 10'd400; req = 2'b01;
        wait_send("t4a");
        req = 2'b00;
        wait_check("t4a");
        rx_valid = 1'b1; rx_pos = 10'd401;
        cyc();
        chk("t4_mismatch", int'({match, mismatch, timeout}), 3'b010);
        req = 2'b01;
        wait_send("t4b");
        req = 2'b00;
        wait_check("t4b");
        begin
            int n = 0;
            while (!timeout && n < 5000) begin cyc(); n++; end
            chk("t4_tmo_latency", n, RT);
        end

        // Reply in the very cycle the wait expires: match wins
        pos0 = 10'd77; req = 2'b01;
        wait_send("t5");
        req = 2'b00;
        wait_check("t5");
        repeat (RT - 1) cyc();
        rx_valid = 1'b1; rx_pos = 10'd77;
        cyc();
        chk("t5_result", int'({match, mismatch, timeout}), 3'b100);

        // Reset during SEND aborts the frame without any result
        pos0 = 10'd300; req = 2'b01;
        wait_send("t6");
        req = 2'b00;
        repeat (20) cyc();
        reset = 1'b1;
        #1;
        chk("t6_gnt", int'(gnt), 0);
        chk("t6_pos", int'(pos_out), 0);
        chk("t6_rate", int'(rate_sel), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_pulses", int'({match, mismatch, timeout}), 0);
        cyc();
        reset = 1'b0;
        repeat (50) cyc();
        chk("t6_busy_after", int'(busy), 0);

        // Randomized soak against the model
        tick_dense = 1'b0;
        for (int i = 0; i < 25000; i++) begin
            cyc();
            if ($urandom_range(7) == 0) req = 2'($urandom_range(3));
            pos0 = 10'($urandom);
            pos1 = 10'($urandom);
            if ($urandom_range(63) == 0) begin
                rate_wr = 1'b1; rate_new = 3'($urandom);
            end
            if (m_in_check ? ($urandom_range(19) == 0) : ($urandom_range(199) == 0)) begin
                rx_valid = 1'b1;
                rx_pos = ($urandom_range(1) == 1) ? m_pos : 10'($urandom);
            end
        end
        req = 2'b00;
        repeat (10) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
